// File: rtl/branch_pkg.sv
// Shared types and constants for the EX-stage branch resolution logic.
`ifndef DATA_WID
`define DATA_WID 32
`endif

package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } funct3_e;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } br_state_e;

  typedef struct packed {
    logic [`DATA_WID-1:0] pc;
    logic                 predict;
    logic                 actual;
    logic                 branch;
  } br_update_t;

  localparam int SQUASH_CNT_W = 3;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator; funct3 codes 010/011 resolve as not taken.
`ifndef DATA_WID
`define DATA_WID 32
`endif

module branch_cmp
  import branch_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [`DATA_WID-1:0] rs1,
  input  logic [`DATA_WID-1:0] rs2,
  output logic                 cmp
);

  logic signed [`DATA_WID-1:0] rs1_s;
  logic signed [`DATA_WID-1:0] rs2_s;

  assign rs1_s = rs1;
  assign rs2_s = rs2;

  always_comb begin
    cmp = 1'b0;
    case (funct3)
      BEQ:     cmp = (rs1 == rs2);
      BNE:     cmp = (rs1 != rs2);
      BLT:     cmp = (rs1_s <  rs2_s);
      BGE:     cmp = (rs1_s >= rs2_s);
      BLTU:    cmp = (rs1 <  rs2);
      BGEU:    cmp = (rs1 >= rs2);
      default: cmp = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: predictor feedback, redirect and wrong-path squash.
// Optional statistics counters are built only when BRANCH_STAT_EN is defined.
`ifndef DATA_WID
`define DATA_WID 32
`endif

module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int                   SQUASH_CYCLES = 2,
  parameter logic [`DATA_WID-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 stall,
  input  logic                 branch,
  input  logic                 ujtype,
  input  logic                 jalr,
  input  logic [2:0]           funct3,
  input  logic [`DATA_WID-1:0] rs1_data,
  input  logic [`DATA_WID-1:0] rs2_data,
  input  logic [`DATA_WID-1:0] pc,
  input  logic [`DATA_WID-1:0] imm,
  input  logic                 predict,
  output logic [`DATA_WID-1:0] old_pc,
  output logic                 old_predict,
  output logic                 old_actual,
  output logic                 old_branch,
  output logic                 redirect_valid,
  output logic [`DATA_WID-1:0] redirect_pc,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispredict_cnt
);

  br_state_e                state;
  br_state_e                state_nxt;
  logic [SQUASH_CNT_W-1:0]  cnt;
  logic [SQUASH_CNT_W-1:0]  cnt_nxt;

  logic                     cmp;
  logic                     accept;
  logic                     rec;
  logic                     is_jalr;
  logic                     actual;
  logic                     jalr_miss;
  logic                     mispredict;
  logic [`DATA_WID-1:0]     seq_tgt;
  logic [`DATA_WID-1:0]     jalr_tgt;
  logic [`DATA_WID-1:0]     taken_tgt;
  logic [`DATA_WID-1:0]     fall_tgt;
  br_update_t               upd_p0;

  br_update_t               upd_p1;
  logic                     redirect_valid_p1;
  logic [`DATA_WID-1:0]     redirect_pc_p1;

  branch_cmp u_cmp (
    .funct3 (funct3),
    .rs1    (rs1_data),
    .rs2    (rs2_data),
    .cmp    (cmp)
  );

  // Stage 0: resolve outcome, targets and mispredict from live EX operands
  assign accept    = ex_valid && !stall && (state == RUN);
  assign rec       = accept && (branch || ujtype);
  assign is_jalr   = ujtype && jalr;
  assign actual    = branch ? cmp : ujtype;
  assign seq_tgt   = pc + imm;
  assign jalr_tgt  = (rs1_data + imm) & PC_ALIGN_MASK;
  assign taken_tgt = is_jalr ? jalr_tgt : seq_tgt;
  assign fall_tgt  = pc + `DATA_WID'(4);
  // A predicted-taken jalr whose BTB target (pc+imm) is wrong must still flush the predictor.
  assign jalr_miss  = is_jalr && predict && (seq_tgt != jalr_tgt);
  assign mispredict = branch ? (predict != actual) : (!predict || jalr_miss);

  always_comb begin
    upd_p0         = '0;
    upd_p0.pc      = pc;
    upd_p0.predict = jalr_miss ? 1'b0 : predict;
    upd_p0.actual  = jalr_miss ? 1'b1 : actual;
    upd_p0.branch  = branch;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (rec && mispredict) begin
          state_nxt = SQUASH;
          cnt_nxt   = SQUASH_CNT_W'(SQUASH_CYCLES - 1);
        end
      end
      SQUASH: begin
        if (!stall) begin
          if (cnt == '0) state_nxt = RUN;
          else           cnt_nxt   = cnt - SQUASH_CNT_W'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Stage 1: registered predictor feedback and redirect
  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= RUN;
      cnt               <= '0;
      upd_p1            <= '0;
      redirect_valid_p1 <= 1'b0;
      redirect_pc_p1    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (rec) begin
        upd_p1            <= upd_p0;
        redirect_valid_p1 <= mispredict;
        redirect_pc_p1    <= actual ? taken_tgt : fall_tgt;
      end else begin
        upd_p1.predict    <= 1'b0;
        upd_p1.actual     <= 1'b0;
        upd_p1.branch     <= 1'b0;
        redirect_valid_p1 <= 1'b0;
      end
    end
  end

  assign old_pc         = upd_p1.pc;
  assign old_predict    = upd_p1.predict;
  assign old_actual     = upd_p1.actual;
  assign old_branch     = upd_p1.branch;
  assign redirect_valid = redirect_valid_p1;
  assign redirect_pc    = redirect_pc_p1;

`ifdef BRANCH_STAT_EN
  logic [31:0] branch_cnt_p1;
  logic [31:0] mispredict_cnt_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      branch_cnt_p1     <= '0;
      mispredict_cnt_p1 <= '0;
    end else begin
      if (rec)               branch_cnt_p1     <= branch_cnt_p1 + 32'd1;
      if (rec && mispredict) mispredict_cnt_p1 <= mispredict_cnt_p1 + 32'd1;
    end
  end

  assign branch_cnt     = branch_cnt_p1;
  assign mispredict_cnt = mispredict_cnt_p1;
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

endmodule
